// File: rtl/clk_div_ctrl.sv
// Runtime-programmable tick divider with start/stop sequencing and a boundary-aligned ratio handshake.
// Optional tick counter output enabled by defining CLK_DIV_CTRL_TICK_CNT_EN.
module clk_div_ctrl #(
  parameter int CNT_W     = 8,
  parameter int RATIO_RST = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             testmode_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_ratio_i,
  output logic             cfg_ready_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] ratio_o,
  output logic             tick_o,
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  output logic [15:0]      tick_cnt_o,
`endif
  output logic             clk_o
);

  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(RATIO_RST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_ratio;
  logic [CNT_W-1:0] r_pend_ratio;
  logic             r_pend;
  logic             r_tick;
  logic             r_err;
  logic             w_bnd;
  logic             w_xfer;
  logic             w_zero;

  // A boundary is the last count of a period; tick, ratio apply and stop exit all key off it.
  assign w_bnd  = (r_state != ST_IDLE) && (r_cnt == (r_ratio - ONE));
  assign w_xfer = cfg_valid_i && !r_pend;
  assign w_zero = (cfg_ratio_i == ZERO);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-count decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = ZERO;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STOP: begin
        if (w_bnd) begin
          w_state_nxt = ST_IDLE;
        end else if (start_i) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if ((r_state == ST_IDLE) || w_bnd) begin
      w_cnt_nxt = ZERO;
    end else begin
      w_cnt_nxt = r_cnt + ONE;
    end
  end

  // Counter, tick and error pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= ZERO;
      r_tick <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= w_bnd;
      r_err  <= w_xfer && w_zero;
    end
  end

  // Ratio register; a pending value is only ever applied at a boundary, never on its accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ratio      <= RST_RATIO;
      r_pend_ratio <= RST_RATIO;
      r_pend       <= 1'b0;
    end else if (w_bnd && r_pend) begin
      r_ratio <= r_pend_ratio;
      r_pend  <= 1'b0;
    end else if (w_xfer && !w_zero) begin
      if (r_state == ST_IDLE) begin
        r_ratio <= cfg_ratio_i;
      end else begin
        r_pend_ratio <= cfg_ratio_i;
        r_pend       <= 1'b1;
      end
    end else begin
      r_ratio <= r_ratio;
      r_pend  <= r_pend;
    end
  end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] r_tick_cnt;

  // Tick counter, restarted whenever a run is launched from idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick_cnt <= 16'h0000;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_tick_cnt <= 16'h0000;
    end else if (r_tick) begin
      r_tick_cnt <= r_tick_cnt + 16'h0001;
    end else begin
      r_tick_cnt <= r_tick_cnt;
    end
  end

  assign tick_cnt_o = r_tick_cnt;
`endif

  assign cfg_ready_o = !r_pend;
  assign err_o       = r_err;
  assign busy_o      = (r_state != ST_IDLE);
  assign ratio_o     = r_ratio;
  assign tick_o      = r_tick;
  assign clk_o       = testmode_i ? clk_i : r_tick;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized self-checking bench for clk_div_ctrl against a cycle-level behavioural model.
module tb_clk_div_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       testmode_i, start_i, stop_i, cfg_valid_i;
  logic [7:0] cfg_ratio_i;
  logic       cfg_ready_o, err_o, busy_o, tick_o, clk_o;
  logic [7:0] ratio_o;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_cnt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: mode 0=idle 1=running 2=stopping; pos = cycles elapsed in current period
  int m_mode, m_pos, m_ratio, m_pend_val, m_tcnt;
  bit m_pend, m_tick, m_err;

  clk_div_ctrl #(.CNT_W(8), .RATIO_RST(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .testmode_i  (testmode_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ratio_i (cfg_ratio_i),
    .cfg_ready_o (cfg_ready_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .ratio_o     (ratio_o),
    .tick_o      (tick_o),
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    .tick_cnt_o  (tick_cnt_o),
`endif
    .clk_o       (clk_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_ratio = 4; m_pend = 1'b0; m_pend_val = 0;
    m_tick = 1'b0; m_err = 1'b0; m_tcnt = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit v, input int r);
    bit bnd, xfer;
    int old_mode;
    bnd  = (m_mode != 0) && (m_pos == m_ratio - 1);
    xfer = v && !m_pend;
    if (m_mode == 0 && st) m_tcnt = 0;
    else if (m_tick) m_tcnt = (m_tcnt + 1) % 65536;
    m_tick = bnd;
    m_err  = xfer && (r == 0);
    old_mode = m_mode;
    if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_pos = 0; end
    end else begin
      m_pos = bnd ? 0 : m_pos + 1;
      if (m_mode == 1 && sp) m_mode = 2;
      else if (m_mode == 2 && bnd) m_mode = 0;
      else if (m_mode == 2 && st) m_mode = 1;
    end
    if (bnd && m_pend) begin
      m_ratio = m_pend_val; m_pend = 1'b0;
    end else if (xfer && r != 0) begin
      if (old_mode == 0) m_ratio = r;
      else begin m_pend = 1'b1; m_pend_val = r; end
    end
  endtask

  task automatic check_all();
    chk("tick",  {31'd0, tick_o},      {31'd0, m_tick});
    chk("err",   {31'd0, err_o},       {31'd0, m_err});
    chk("busy",  {31'd0, busy_o},      (m_mode != 0) ? 32'd1 : 32'd0);
    chk("ratio", {24'd0, ratio_o},     m_ratio);
    chk("ready", {31'd0, cfg_ready_o}, {31'd0, !m_pend});
    chk("clk_o", {31'd0, clk_o},       {31'd0, (testmode_i ? clk_i : m_tick)});
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    chk("tick_cnt", {16'd0, tick_cnt_o}, m_tcnt);
`endif
  endtask

  task automatic step(input bit st, input bit sp, input bit v, input int r, input bit tm);
    start_i = st; stop_i = sp; cfg_valid_i = v; cfg_ratio_i = 8'(r); testmode_i = tm;
    @(posedge clk_i);
    model_edge(st, sp, v, r);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit tm);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, tm);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    rst_ni = 1'b0;
    #2;
    model_reset();
    check_all();
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; testmode_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    cfg_valid_i = 1'b0; cfg_ratio_i = 8'd0;
    model_reset();
    #12;
    check_all();
    #1 rst_ni = 1'b1;

    // Default ratio 4: first tick four edges after start
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(3, 1'b0);
    chk("first_tick_early", {31'd0, tick_o}, 32'd0);
    idle(1, 1'b0);
    chk("first_tick", {31'd0, tick_o}, 32'd1);
    idle(8, 1'b0);

    // Ratio update to 6 offered at cnt=1 of a period
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 6, 1'b0);
    chk("pend_ready_low", {31'd0, cfg_ready_o}, 32'd0);
    idle(16, 1'b0);

    // Zero ratio rejected in idle and in run
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(8, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("err_idle", {31'd0, err_o}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle(8, 1'b0);

    // Ratio 5: stop at cnt=1, then stop cancelled by start at cnt=3
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(8, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(10, 1'b0);
    chk("stopped_idle", {31'd0, busy_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(15, 1'b0);

    // Ratio 1 with test-mode bypass
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(8, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);
    chk("clk_o_bypass", {31'd0, clk_o}, 32'd1);

    // Reset mid-period with a ratio pending
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 7, 1'b0);
    pulse_reset();
    chk("rst_ratio", {24'd0, ratio_o}, 32'd4);
    idle(6, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) pulse_reset();
      step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 15) == 0);
    end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    pulse_reset();
    step(1'b0, 1'b0, 1'b1, 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(65540, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
